// File: rtl/uc_pkg.sv
// uc_pkg: shared opcode, control-field encodings and FSM state type for the sequenced control unit.
package uc_pkg;
  localparam int OP_ADD = 0, OP_SUB = 1, OP_MUL = 2, OP_DIV = 3;
  localparam int OP_ADDI = 4, OP_SUBI = 5, OP_MULI = 6, OP_DIVI = 7;
  localparam int OP_NOT = 8, OP_AND = 9, OP_OR = 10, OP_XOR = 11, OP_MOD = 12;
  localparam int OP_SL = 13, OP_SR = 14, OP_JMP = 15, OP_JE = 16, OP_JB = 17;
  localparam int OP_JA = 18, OP_JNE = 19, OP_JBE = 20, OP_JAE = 21, OP_JZ = 22;
  localparam int OP_JNZ = 23, OP_MOV = 24, OP_NOP = 25, OP_HLT = 26;
  localparam int OP_PUSH = 27, OP_POP = 28, OP_MOVI = 29;
  localparam int ALU_NONE = 0, ALU_ADD = 1, ALU_SUB = 2, ALU_MUL = 3, ALU_DIV = 4;
  localparam int ALU_MOD = 5, ALU_OR = 6, ALU_AND = 7, ALU_NOT = 9, ALU_SR = 10;
  localparam int ALU_XOR = 11, ALU_SL = 12, ALU_MOVE = 14;
  localparam int PC_NONE = 0, PC_JE = 1, PC_JB = 2, PC_JA = 3, PC_JNE = 4, PC_JBE = 5;
  localparam int PC_JAE = 6, PC_JNZ = 7, PC_JZ = 8, PC_JMP = 9, PC_HALT = 10, PC_TRAP = 11;
  localparam logic [1:0] SS_NONE = 2'd0, SS_PUSH = 2'd1, SS_POP = 2'd2;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_STACK_WAIT, S_HALT} state_t;
endpackage

// File: rtl/uc_decode.sv
// uc_decode: combinational opcode decoder; UC_SEQ_ILLEGAL_TRAP_EN sends unknown opcodes to the trap vector instead of halt.
module uc_decode
  import uc_pkg::*;
#(
  parameter int OPC_W = 6,
  parameter int ALU_W = 6,
  parameter int PC_W  = 5
) (
  input  logic [OPC_W-1:0] opcode_i,
  output logic [ALU_W-1:0] alucode_o,
  output logic             im_control_o,
  output logic             write_code_o,
  output logic [PC_W-1:0]  pc_control_o,
  output logic [1:0]       stack_select_o,
  output logic             is_illegal_o
);
  int a, p;
  always_comb begin
    a = ALU_NONE;
    p = PC_NONE;
    im_control_o = 1'b0;
    write_code_o = 1'b0;
    stack_select_o = SS_NONE;
    is_illegal_o = 1'b0;
    case (int'(opcode_i))
      OP_ADD: a = ALU_ADD;
      OP_SUB: a = ALU_SUB;
      OP_MUL: a = ALU_MUL;
      OP_DIV: a = ALU_DIV;
      OP_ADDI: begin a = ALU_ADD; im_control_o = 1'b1; end
      OP_SUBI: begin a = ALU_SUB; im_control_o = 1'b1; end
      OP_MULI: begin a = ALU_MUL; im_control_o = 1'b1; end
      OP_DIVI: begin a = ALU_DIV; im_control_o = 1'b1; end
      OP_NOT: a = ALU_NOT;
      OP_AND: a = ALU_AND;
      OP_OR: a = ALU_OR;
      OP_XOR: a = ALU_XOR;
      OP_MOD: a = ALU_MOD;
      OP_SL: a = ALU_SL;
      OP_SR: a = ALU_SR;
      OP_JMP: begin a = ALU_MOVE; p = PC_JMP; end
      OP_JE: begin a = ALU_MOVE; p = PC_JE; end
      OP_JB: begin a = ALU_MOVE; p = PC_JB; end
      OP_JA: begin a = ALU_MOVE; p = PC_JA; end
      OP_JNE: begin a = ALU_MOVE; p = PC_JNE; end
      OP_JBE: begin a = ALU_MOVE; p = PC_JBE; end
      OP_JAE: begin a = ALU_MOVE; p = PC_JAE; end
      OP_JZ: begin a = ALU_MOVE; p = PC_JZ; end
      OP_JNZ: begin a = ALU_MOVE; p = PC_JNZ; end
      OP_MOV: begin a = ALU_MOVE; write_code_o = 1'b1; end
      OP_MOVI: begin a = ALU_MOVE; write_code_o = 1'b1; im_control_o = 1'b1; end
      OP_NOP: a = ALU_NONE;
      OP_HLT: p = PC_HALT;
      OP_PUSH: begin im_control_o = 1'b1; stack_select_o = SS_PUSH; end
      OP_POP: begin im_control_o = 1'b1; stack_select_o = SS_POP; end
      default: begin
        is_illegal_o = 1'b1;
`ifdef UC_SEQ_ILLEGAL_TRAP_EN
        p = PC_TRAP;
`else
        p = PC_HALT;
`endif
      end
    endcase
    alucode_o = ALU_W'(a);
    pc_control_o = PC_W'(p);
  end
endmodule

// File: rtl/uc_seq.sv
// uc_seq: multi-cycle FETCH/DECODE/EXEC control unit with stack stall and HALT.
// Unknown-opcode handling is selected by UC_SEQ_ILLEGAL_TRAP_EN inside uc_decode.
module uc_seq
  import uc_pkg::*;
#(
  parameter int INSTR_W   = 32,
  parameter int OPC_W     = 6,
  parameter int REG_SEL_W = 3,
  parameter int ALU_W     = 6,
  parameter int PC_W      = 5,
  localparam int IMM_W    = INSTR_W - OPC_W - REG_SEL_W - 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [INSTR_W-1:0]   instruction,
  input  logic                 stack_ack,
  output logic [REG_SEL_W-1:0] op1,
  output logic [IMM_W-1:0]     op2,
  output logic                 flag,
  output logic                 flag1,
  output logic [ALU_W-1:0]     alucode,
  output logic                 im_control,
  output logic                 write_code,
  output logic [PC_W-1:0]      pc_control,
  output logic [1:0]           stack_select,
  output logic                 ctrl_valid,
  output logic                 halted,
  output logic                 illegal_op
);
  state_t state_q;
  logic [INSTR_W-1:0] ir_q;
  logic [ALU_W-1:0] alucode_q, dec_alucode;
  logic [PC_W-1:0] pc_q, dec_pc;
  logic [1:0] ss_q, dec_ss;
  logic im_q, wc_q, cv_q, halted_q, ready_q, illegal_q;
  logic dec_im, dec_wc, dec_illegal;

  uc_decode #(.OPC_W(OPC_W), .ALU_W(ALU_W), .PC_W(PC_W)) u_dec (
    .opcode_i(ir_q[INSTR_W-1 -: OPC_W]),
    .alucode_o(dec_alucode),
    .im_control_o(dec_im),
    .write_code_o(dec_wc),
    .pc_control_o(dec_pc),
    .stack_select_o(dec_ss),
    .is_illegal_o(dec_illegal)
  );

  assign op1 = ir_q[INSTR_W-OPC_W-2 -: REG_SEL_W];
  assign op2 = ir_q[IMM_W-1:0];
  assign flag = ir_q[INSTR_W-OPC_W-1];
  assign flag1 = ir_q[IMM_W];
  assign alucode = alucode_q;
  assign im_control = im_q;
  assign write_code = wc_q;
  assign pc_control = pc_q;
  assign stack_select = ss_q;
  assign ctrl_valid = cv_q;
  assign halted = halted_q;
  assign instr_ready = ready_q;
  assign illegal_op = illegal_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      ir_q <= '0;
      alucode_q <= '0;
      pc_q <= '0;
      ss_q <= SS_NONE;
      im_q <= 1'b0;
      wc_q <= 1'b0;
      cv_q <= 1'b0;
      halted_q <= 1'b0;
      ready_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (ready_q && instr_valid) begin
            ir_q <= instruction;
            ready_q <= 1'b0;
            state_q <= S_DECODE;
          end else begin
            ready_q <= 1'b1;
          end
        end
        S_DECODE: begin
          alucode_q <= dec_alucode;
          im_q <= dec_im;
          wc_q <= dec_wc;
          pc_q <= dec_pc;
          ss_q <= dec_ss;
          cv_q <= 1'b1;
          illegal_q <= illegal_q | dec_illegal;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          // PC_HALT here means either HLT or an untrapped unknown opcode
          if (ss_q != SS_NONE) begin
            state_q <= S_STACK_WAIT;
          end else if (pc_q == PC_W'(PC_HALT)) begin
            alucode_q <= '0;
            im_q <= 1'b0;
            wc_q <= 1'b0;
            cv_q <= 1'b0;
            halted_q <= 1'b1;
            state_q <= S_HALT;
          end else begin
            alucode_q <= '0;
            im_q <= 1'b0;
            wc_q <= 1'b0;
            pc_q <= '0;
            cv_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= S_FETCH;
          end
        end
        S_STACK_WAIT: begin
          if (stack_ack) begin
            alucode_q <= '0;
            im_q <= 1'b0;
            wc_q <= 1'b0;
            pc_q <= '0;
            ss_q <= SS_NONE;
            cv_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= S_FETCH;
          end
        end
        S_HALT: state_q <= S_HALT;
        default: state_q <= S_FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_uc_seq.sv
// tb_uc_seq: scoreboard bench for uc_seq; expected controls queued at handshake, checked when ctrl_valid rises.
module tb_uc_seq;
  logic clock = 1'b0, reset = 1'b1, instr_valid = 1'b0, stack_ack = 1'b0;
  logic [31:0] instruction = '0;
  logic instr_ready, flag, flag1, im_control, write_code, ctrl_valid, halted, illegal_op;
  logic [2:0] op1;
  logic [20:0] op2;
  logic [5:0] alucode;
  logic [4:0] pc_control;
  logic [1:0] stack_select;

  typedef struct packed {
    logic [5:0] alu;
    logic im, wc;
    logic [4:0] pc;
    logic [1:0] ss;
    logic [2:0] op1;
    logic [20:0] op2;
    logic flag, flag1;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int vectors = 0, miscompares = 0, cyc = 0, last_acc = 0;
  logic prev_cv = 1'b0;
  int ops[20] = '{0, 1, 2, 3, 5, 6, 7, 8, 9, 10, 11, 12, 14, 15, 16, 17, 18, 21, 24, 29};

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  uc_seq dut (
    .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instruction(instruction), .stack_ack(stack_ack), .op1(op1), .op2(op2), .flag(flag),
    .flag1(flag1), .alucode(alucode), .im_control(im_control), .write_code(write_code),
    .pc_control(pc_control), .stack_select(stack_select), .ctrl_valid(ctrl_valid),
    .halted(halted), .illegal_op(illegal_op)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(int opc, int fl, int r, int fl1, int imm);
    return {6'(opc), 1'(fl), 3'(r), 1'(fl1), 21'(imm)};
  endfunction

  function automatic exp_t model(logic [31:0] w, int c);
    exp_t e;
    int opc;
    int jpc[9] = '{9, 1, 2, 3, 4, 5, 6, 8, 7};
    opc = int'(w[31:26]);
    e = '0;
    e.op1 = w[24:22]; e.op2 = w[20:0]; e.flag = w[25]; e.flag1 = w[21]; e.cyc = c;
    case (opc)
      0, 4: e.alu = 1;
      1, 5: e.alu = 2;
      2, 6: e.alu = 3;
      3, 7: e.alu = 4;
      12: e.alu = 5;
      10: e.alu = 6;
      9: e.alu = 7;
      8: e.alu = 9;
      14: e.alu = 10;
      11: e.alu = 11;
      13: e.alu = 12;
      15, 16, 17, 18, 19, 20, 21, 22, 23: begin e.alu = 14; e.pc = 5'(jpc[opc-15]); end
      24: begin e.alu = 14; e.wc = 1; end
      29: begin e.alu = 14; e.wc = 1; e.im = 1; end
      25: e.alu = 0;
      26: e.pc = 10;
      27: begin e.im = 1; e.ss = 1; end
      28: begin e.im = 1; e.ss = 2; end
`ifdef UC_SEQ_ILLEGAL_TRAP_EN
      default: e.pc = 11;
`else
      default: e.pc = 10;
`endif
    endcase
    if (opc >= 4 && opc <= 7) e.im = 1;
    return e;
  endfunction

  always @(negedge clock) begin : mon
    exp_t e;
    if (ctrl_valid && !prev_cv) begin
      if (sb.size() == 0) chk("spurious_ctrl_valid", 1, 0);
      else begin
        e = sb.pop_front();
        chk("alucode", alucode, e.alu);
        chk("im_control", im_control, e.im);
        chk("write_code", write_code, e.wc);
        chk("pc_control", pc_control, e.pc);
        chk("stack_select", stack_select, e.ss);
        chk("op1", op1, e.op1);
        chk("op2", op2, e.op2);
        chk("flag", flag, e.flag);
        chk("flag1", flag1, e.flag1);
        chk("latency_cycle", cyc, e.cyc);
      end
    end
    if (!ctrl_valid && !reset) chk("idle_controls", {alucode, im_control, write_code, stack_select}, 0);
    prev_cv = ctrl_valid;
  end

  task automatic issue(input logic [31:0] w);
    int n = 0;
    @(negedge clock);
    instr_valid = 1'b1;
    instruction = w;
    while (!instr_ready && n < 30) begin
      @(negedge clock);
      n++;
    end
    if (!instr_ready) chk("accept_timeout", 0, 1);
    else begin
      last_acc = cyc;
      sb.push_back(model(w, cyc + 2));
    end
    @(negedge clock);
    instr_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!instr_ready && n < 30);
    if (!instr_ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic reset_check();
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rst_ready", instr_ready, 0);
    chk("rst_halted", halted, 0);
    chk("rst_ctrl_valid", ctrl_valid, 0);
    chk("rst_pc", pc_control, 0);
    chk("rst_ir", {op1, op2, flag, flag1}, 0);
    chk("rst_illegal", illegal_op, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_ready", instr_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset_check();
    // ADDI op1=3 op2=5
    issue(mk(4, 0, 3, 0, 5));
    wait_ready();
    chk("addi_throughput", cyc - last_acc, 3);
    // PUSH stalls until stack_ack
    issue(mk(27, 1, 6, 0, 21'h1abcd));
    repeat (4) begin
      @(negedge clock);
      chk("push_ctrl_valid", ctrl_valid, 1);
      chk("push_stack_select", stack_select, 1);
    end
    stack_ack = 1'b1;
    @(negedge clock);
    chk("ack_to_fetch", instr_ready, 1);
    chk("ack_ctrl_valid", ctrl_valid, 0);
    @(negedge clock);
    chk("stray_ack_fetch", instr_ready, 1);
    stack_ack = 1'b0;
    // POP with ack raised during EXEC, which must be ignored
    issue(mk(28, 0, 2, 1, 77));
    @(negedge clock);
    stack_ack = 1'b1;
    @(negedge clock);
    chk("pop_exec_ack_ignored", ctrl_valid, 1);
    @(negedge clock);
    chk("pop_done", instr_ready, 1);
    stack_ack = 1'b0;
    // JNZ, idle gap, SL
    issue(mk(23, 0, 1, 1, 100));
    wait_ready();
    repeat (3) @(negedge clock);
    issue(mk(13, 1, 2, 0, 7));
    wait_ready();
    for (int i = 0; i < 20; i++) begin
      issue(mk(ops[i], int'($urandom_range(1)), int'($urandom_range(7)), int'($urandom_range(1)), int'($urandom)));
      wait_ready();
      chk("throughput", cyc - last_acc, 3);
    end
    // HLT
    issue(mk(26, 0, 0, 0, 0));
    repeat (2) @(negedge clock);
    chk("halt_halted", halted, 1);
    chk("halt_pc", pc_control, 10);
    chk("halt_ctrl_valid", ctrl_valid, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      instr_valid = 1'b1;
      instruction = mk(0, 0, 1, 0, i);
      chk("halt_ready", instr_ready, 0);
      @(negedge clock);
      instr_valid = 1'b0;
    end
    reset_check();
    // unknown opcode 45
    issue(mk(45, 1, 5, 1, 3));
    @(negedge clock);
    @(negedge clock);
    chk("illegal_set", illegal_op, 1);
`ifdef UC_SEQ_ILLEGAL_TRAP_EN
    chk("trap_resume", instr_ready, 1);
    chk("trap_not_halted", halted, 0);
    issue(mk(0, 0, 4, 0, 9));
    wait_ready();
    chk("illegal_sticky", illegal_op, 1);
`else
    chk("illegal_halted", halted, 1);
    chk("illegal_pc", pc_control, 10);
    chk("illegal_ready", instr_ready, 0);
`endif
    reset_check();
    // async reset in the middle of STACK_WAIT
    issue(mk(27, 0, 7, 0, 55));
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("async_ctrl_valid", ctrl_valid, 0);
    chk("async_stack_select", stack_select, 0);
    chk("async_ready", instr_ready, 0);
    chk("async_op2", op2, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("async_post_ready", instr_ready, 1);
    issue(mk(1, 1, 3, 1, 1234));
    wait_ready();
    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
